// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared definitions for the DataMemory arbiter slice.
//   - arb_state_t : access sequencer states (IDLE, ACCESS, WAIT, RESP)
//   - NUM_REQ     : number of requesters (core load/store = 0, debug/DMA = 1)
//   - owner_onehot: converts a requester index into its one-hot strobe
package dmem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bus between the two requesters and the
// DataMemory arbiter.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_we              : per-requester write (1) / read (0)
//   req_addr/req_wdata  : packed payloads, requester i at [i*W +: W]
//   resp_valid          : one-cycle response strobe to the owning requester
//   resp_rdata/resp_err : response payload, qualified by resp_valid
// Modports: master (requester side), slave (arbiter side).
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [DW-1:0]         resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-input round-robin pick.
//   req_valid  : request vector (bit i = requester i)
//   last_grant : index of the requester granted most recently
//   grant      : one-hot winner, zero when nobody requests
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the core
// load/store path (requester 0) and the debug/DMA port (requester 1).
// One access at a time: accept -> ACCESS -> WAIT x (MEM_LAT-1) -> RESP.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : request/response bus, see dmem_arbiter_if
//   mem_address      : DataMemory address (passed through unmodified)
//   mem_write_data   : DataMemory write data
//   mem_write_enable : DataMemory write strobe
//   mem_read_enable  : DataMemory read strobe
//   mem_read_data    : DataMemory read data, valid MEM_LAT cycles after
//                      read_enable is sampled
// Optional: define DMEM_ARB_ALIGN_CHECK_EN to reject addresses with
// addr[1:0] != 0 (no memory access, resp_err=1); otherwise resp_err is 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
)(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus,
    output logic [AW-1:0]  mem_address,
    output logic [DW-1:0]  mem_write_data,
    output logic           mem_write_enable,
    output logic           mem_read_enable,
    input  logic [DW-1:0]  mem_read_data
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic               last_grant;
    logic               owner;
    logic               op_we;
    logic               op_err;
    logic [2:0]         lat_cnt;

    logic [NUM_REQ-1:0] grant;
    logic               win;
    logic               accept;
    logic               misaligned;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;

    rr_arbiter2 u_rr (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Winner payload mux; ready is withheld while rst is high so no
    // handshake can complete on a reset edge.
    always_comb begin
        win           = grant[1];
        accept        = (state == IDLE) && (|grant) && !rst;
        bus.req_ready = accept ? grant : '0;
        sel_we        = bus.req_we[win];
        sel_addr      = win ? bus.req_addr[AW +: AW]  : bus.req_addr[0 +: AW];
        sel_wdata     = win ? bus.req_wdata[DW +: DW] : bus.req_wdata[0 +: DW];
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        misaligned    = (sel_addr[1:0] != 2'b00);
`else
        misaligned    = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = misaligned ? RESP : ACCESS;
            ACCESS:  state_nx = (op_we || (MEM_LAT <= 1)) ? RESP : WAIT;
            WAIT:    if (lat_cnt == 3'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory strobes are registered one state ahead so they are high
    // exactly during ACCESS and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            lat_cnt          <= '0;
            owner            <= 1'b0;
            op_we            <= 1'b0;
            op_err           <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            bus.resp_valid   <= '0;
            bus.resp_rdata   <= '0;
            bus.resp_err     <= 1'b0;
        end else begin
            state            <= state_nx;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            bus.resp_valid   <= '0;
            bus.resp_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= win;
                        last_grant <= win;
                        op_we      <= sel_we;
                        op_err     <= misaligned;
                        if (!misaligned) begin
                            mem_address      <= sel_addr;
                            mem_write_data   <= sel_wdata;
                            mem_write_enable <= sel_we;
                            mem_read_enable  <= !sel_we;
                        end
                    end
                end
                ACCESS: begin
                    if (!op_we) begin
                        lat_cnt         <= LAT_M1;
                        mem_read_enable <= (MEM_LAT > 1);
                    end
                end
                WAIT: begin
                    lat_cnt         <= lat_cnt - 3'd1;
                    mem_read_enable <= (lat_cnt != 3'd1);
                end
                RESP: begin
                    bus.resp_valid <= owner_onehot(owner);
                    bus.resp_err   <= op_err;
                    bus.resp_rdata <= (op_we || op_err) ? '0 : mem_read_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each attached to a small word memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    logic [31:0] m1_addr, m1_wd, m1_rd;
    logic        m1_we, m1_re;
    logic [31:0] m3_addr, m3_wd, m3_rd;
    logic        m3_we, m3_re;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .mem_address(m1_addr), .mem_write_data(m1_wd),
        .mem_write_enable(m1_we), .mem_read_enable(m1_re),
        .mem_read_data(m1_rd)
    );

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .mem_address(m3_addr), .mem_write_data(m3_wd),
        .mem_write_enable(m3_we), .mem_read_enable(m3_re),
        .mem_read_data(m3_rd)
    );

    // Memory models: word indexed, read data garbage unless read_enable
    // was sampled exactly MEM_LAT edges earlier.
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] p1, p2, p3;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 32'h0;
            mem1[1] <= 32'h11110004;
            mem1[2] <= 32'h22220008;
        end else if (m1_we) begin
            mem1[6'(m1_addr >> 2)] <= m1_wd;
        end
        m1_rd <= m1_re ? mem1[6'(m1_addr >> 2)] : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 32'h0;
            mem3[4] <= 32'h12345678;
        end else if (m3_we) begin
            mem3[6'(m3_addr >> 2)] <= m3_wd;
        end
        p1 <= m3_re ? mem3[6'(m3_addr >> 2)] : 32'hDEADBEEF;
        p2 <= p1;
        p3 <= p2;
    end
    assign m3_rd = p3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    int          lat, re_cnt, we_cnt, rv_seen;
    int          exp_lat, exp_we_cnt;
    logic [1:0]  rv, exp_g;
    logic [31:0] rd, exp_after;
    logic        re, exp_err;

    initial begin
        bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;

        // Reset state; a request during reset must not be readied.
        repeat (3) tick();
        preload = 1'b0;
        bus1.req_valid = 2'b01;
        #1;
        chk("rst_ready", bus1.req_ready, 2'b00);
        bus1.req_valid = '0;
        chk("rst_resp_valid", bus1.resp_valid, 2'b00);
        chk("rst_resp_rdata", bus1.resp_rdata, 32'h0);
        chk("rst_resp_err", bus1.resp_err, 1'b0);
        chk("rst_mem_strobes", {m1_we, m1_re}, 2'b00);
        chk("rst_mem_addr", m1_addr, 32'h0);
        chk("rst_mem_wdata", m1_wd, 32'h0);
        rst = 1'b0;

        // Single write then read, MEM_LAT=1.
        bus1.req_valid = 2'b01; bus1.req_we = 2'b01;
        bus1.req_addr = '0; bus1.req_wdata = {32'h0, 32'hABCDEF01};
        #1 chk("wr_ready", bus1.req_ready, 2'b01);
        tick(); bus1.req_valid = '0;
        chk("wr_mem_we", {m1_we, m1_re}, 2'b10);
        chk("wr_mem_addr", m1_addr, 32'h0);
        chk("wr_mem_wdata", m1_wd, 32'hABCDEF01);
        tick(); chk("wr_resp_early", bus1.resp_valid, 2'b00);
        tick(); chk("wr_resp", bus1.resp_valid, 2'b01);

        bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr = '0;
        #1 chk("rd_ready", bus1.req_ready, 2'b01);
        tick(); bus1.req_valid = '0;
        chk("rd_mem_re", {m1_we, m1_re}, 2'b01);
        tick(); tick();
        chk("rd_resp", bus1.resp_valid, 2'b01);
        chk("rd_rdata", bus1.resp_rdata, 32'hABCDEF01);

        // Continuous contention; last winner was requester 0, so 1,0,1,0.
        bus1.req_valid = 2'b11; bus1.req_we = 2'b00;
        bus1.req_addr = {32'h8, 32'h4};
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk("cont_ready", bus1.req_ready, exp_g);
            tick(); tick(); tick();
            chk("cont_resp", bus1.resp_valid, exp_g);
            chk("cont_rdata", bus1.resp_rdata, (exp_g == 2'b10) ? 32'h22220008 : 32'h11110004);
        end
        bus1.req_valid = '0;

        // Back-pressure: requester 1 arrives while requester 0 is in flight.
        bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr = {32'h8, 32'h4};
        #1 chk("bp_ready0", bus1.req_ready, 2'b01);
        tick();
        bus1.req_valid = 2'b10; bus1.req_we = 2'b10; bus1.req_wdata = {32'h5A5A5A5A, 32'h0};
        #1 chk("bp_ready_access", bus1.req_ready, 2'b00);
        tick(); chk("bp_ready_resp", bus1.req_ready, 2'b00);
        tick();
        chk("bp_resp0", bus1.resp_valid, 2'b01);
        chk("bp_rdata0", bus1.resp_rdata, 32'h11110004);
        chk("bp_ready1", bus1.req_ready, 2'b10);
        tick(); bus1.req_valid = '0;
        chk("bp_mem_we", {m1_we, m1_re}, 2'b10);
        chk("bp_mem_addr", m1_addr, 32'h8);
        chk("bp_mem_wdata", m1_wd, 32'h5A5A5A5A);
        tick(); tick();
        chk("bp_resp1", bus1.resp_valid, 2'b10);

        // Latency, MEM_LAT=3: requester 1 reads 0x10.
        bus3.req_valid = 2'b10; bus3.req_we = 2'b00; bus3.req_addr = {32'h10, 32'h0};
        #1 chk("lat_ready", bus3.req_ready, 2'b10);
        re_cnt = 0; lat = 0; rv = '0; rd = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tick(); bus3.req_valid = '0;
            if (m3_re) re_cnt++;
            if (bus3.resp_valid != 2'b00) begin
                lat = c; rv = bus3.resp_valid; rd = bus3.resp_rdata;
            end
        end
        chk("lat_cycles", lat, 5);
        chk("lat_resp", rv, 2'b10);
        chk("lat_rdata", rd, 32'h12345678);
        chk("lat_re_cycles", re_cnt, 3);

        // Reset during WAIT.
        bus3.req_valid = 2'b01; bus3.req_addr = {32'h10, 32'h10};
        #1 chk("rm_ready", bus3.req_ready, 2'b01);
        tick(); bus3.req_valid = '0;
        tick(); chk("rm_in_wait", m3_re, 1'b1);
        rst = 1'b1;
        tick();
        chk("rm_resp_valid", bus3.resp_valid, 2'b00);
        chk("rm_mem_strobes", {m3_we, m3_re}, 2'b00);
        chk("rm_mem_addr", m3_addr, 32'h0);
        rst = 1'b0;
        rv_seen = 0;
        repeat (4) begin
            tick();
            if (bus3.resp_valid != 2'b00) rv_seen = 1;
        end
        chk("rm_no_resp", rv_seen, 0);
        bus3.req_valid = 2'b11;
        #1 chk("rm_tie_ready", bus3.req_ready, 2'b01);
        tick(); bus3.req_valid = '0;
        repeat (4) tick();
        chk("rm_tie_resp", bus3.resp_valid, 2'b01);
        chk("rm_tie_rdata", bus3.resp_rdata, 32'h12345678);

        // Misaligned write to 0x2, then read back 0x0.
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        exp_lat = 2; exp_err = 1'b1; exp_we_cnt = 0; exp_after = 32'hABCDEF01;
`else
        exp_lat = 3; exp_err = 1'b0; exp_we_cnt = 1; exp_after = 32'hFFFFFFFF;
`endif
        bus1.req_valid = 2'b01; bus1.req_we = 2'b01;
        bus1.req_addr = {32'h0, 32'h2}; bus1.req_wdata = {32'h0, 32'hFFFFFFFF};
        #1 chk("al_ready", bus1.req_ready, 2'b01);
        we_cnt = 0; lat = 0; rv = '0; re = 1'bx;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tick(); bus1.req_valid = '0;
            if (m1_we) we_cnt++;
            if (bus1.resp_valid != 2'b00) begin
                lat = c; rv = bus1.resp_valid; re = bus1.resp_err; rd = bus1.resp_rdata;
            end
        end
        chk("al_cycles", lat, exp_lat);
        chk("al_resp", rv, 2'b01);
        chk("al_err", re, exp_err);
        chk("al_rdata", rd, 32'h0);
        chk("al_we_count", we_cnt, exp_we_cnt);
        bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr = '0;
        #1;
        tick(); bus1.req_valid = '0;
        tick(); tick();
        chk("al_readback_resp", bus1.resp_valid, 2'b01);
        chk("al_readback", bus1.resp_rdata, exp_after);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
